// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between MEM and a req/ack data-memory port, with a load hazard check (SB_FWD_EN adds full-word forwarding).
// Latency: a store pushed at edge N is presented on Mem_* in cycle N+1; drains 1 entry/cycle while Mem_Ack is high.
// Backpressure: Stall for a store into a full buffer (unless the head retires that cycle) or for an unforwardable load match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          St_Req,
    input  logic [AW-1:0] St_Addr,
    input  logic [31:0]   St_Data,
    input  logic [3:0]    St_BE,
    input  logic          Ld_Req,
    input  logic [AW-1:0] Ld_Addr,
    output logic          Ld_Fwd,
    output logic [31:0]   Ld_Data,
    output logic          Stall,
    output logic          Full,
    output logic          Empty,
    output logic          Mem_Req,
    output logic [AW-1:0] Mem_Addr,
    output logic [31:0]   Mem_Data,
    output logic [3:0]    Mem_BE,
    input  logic          Mem_Ack
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    typedef struct packed {
        logic          vld;
        logic [WW-1:0] waddr;
        logic [31:0]   dat;
        logic [3:0]    be;
    } entry_t;

    entry_t        ent [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [0:0]    state;
    logic [0:0]    state_nxt;

    logic push;
    logic pop;
    logic st_stall;
    logic ld_stall;
    logic ld_hit;
    logic ld_fwd_ok;
    logic unused_addr_lsbs;

    // Byte offsets never matter: matching and draining work on whole words.
    assign unused_addr_lsbs = ^{St_Addr[1:0], Ld_Addr[1:0]};

`ifdef SB_FWD_EN
    logic [PW-1:0] ld_yidx;
`endif

    // Walk oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        ld_hit = 1'b0;
`ifdef SB_FWD_EN
        ld_yidx = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[rd_ptr + PW'(i)].vld && (ent[rd_ptr + PW'(i)].waddr == Ld_Addr[AW-1:2])) begin
                ld_hit = 1'b1;
`ifdef SB_FWD_EN
                ld_yidx = rd_ptr + PW'(i);
`endif
            end
        end
    end

`ifdef SB_FWD_EN
    assign ld_fwd_ok = (ent[ld_yidx].be == 4'hF);
    assign Ld_Fwd    = Ld_Req && !St_Req && ld_hit && ld_fwd_ok;
    assign Ld_Data   = Ld_Fwd ? ent[ld_yidx].dat : 32'h0;
`else
    assign ld_fwd_ok = 1'b0;
    assign Ld_Fwd    = 1'b0;
    assign Ld_Data   = 32'h0;
`endif

    assign Mem_Req  = (state == S_REQ);
    assign Mem_Addr = Mem_Req ? {ent[rd_ptr].waddr, 2'b00} : '0;
    assign Mem_Data = Mem_Req ? ent[rd_ptr].dat : 32'h0;
    assign Mem_BE   = Mem_Req ? ent[rd_ptr].be : 4'h0;

    assign Full  = (count == (PW+1)'(DEPTH));
    assign Empty = (count == '0);

    assign pop      = Mem_Req && Mem_Ack;
    assign st_stall = St_Req && Full && !pop;
    // A simultaneous store wins the cycle, so the load side stays quiet.
    assign ld_stall = Ld_Req && !St_Req && ld_hit && !ld_fwd_ok;
    assign Stall    = st_stall || ld_stall;
    assign push     = St_Req && !Stall;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (push) state_nxt = S_REQ;
            S_REQ:  if (pop && (count == (PW+1)'(1)) && !push) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (pop) begin
                ent[rd_ptr].vld <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            // Full buffer with push+pop reuses the retiring slot; the write below wins.
            if (push) begin
                ent[wr_ptr] <= '{vld: 1'b1, waddr: St_Addr[AW-1:2], dat: St_Data, be: St_BE};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based model predicts each cycle and each memory beat; a monitor compares.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 12;
`ifdef SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } st_t;

    typedef struct packed {
        logic          stall;
        logic          fwd;
        logic [31:0]   ldata;
        logic          full;
        logic          empty;
        logic          mreq;
        logic [AW-1:0] maddr;
        logic [31:0]   mdata;
        logic [3:0]    mbe;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          St_Req = 1'b0;
    logic [AW-1:0] St_Addr = '0;
    logic [31:0]   St_Data = '0;
    logic [3:0]    St_BE = '0;
    logic          Ld_Req = 1'b0;
    logic [AW-1:0] Ld_Addr = '0;
    logic          Ld_Fwd;
    logic [31:0]   Ld_Data;
    logic          Stall;
    logic          Full;
    logic          Empty;
    logic          Mem_Req;
    logic [AW-1:0] Mem_Addr;
    logic [31:0]   Mem_Data;
    logic [3:0]    Mem_BE;
    logic          Mem_Ack = 1'b0;

    st_t  pend[$];
    st_t  beatq[$];
    exp_t cycq[$];
    int   tests = 0;
    int   fails = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .St_Req(St_Req), .St_Addr(St_Addr), .St_Data(St_Data), .St_BE(St_BE),
        .Ld_Req(Ld_Req), .Ld_Addr(Ld_Addr), .Ld_Fwd(Ld_Fwd), .Ld_Data(Ld_Data),
        .Stall(Stall), .Full(Full), .Empty(Empty),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_BE(Mem_BE),
        .Mem_Ack(Mem_Ack)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pend holds the pending stores oldest first.
    function automatic exp_t predict(input logic st, input logic ld, input logic [AW-1:0] la,
                                     input logic ack, output logic push, output logic pop);
        exp_t e;
        int   n;
        int   y;
        logic st_stall;
        logic ld_stall;
        n = pend.size();
        y = -1;
        e = '0;
        pop = (n > 0) && ack;
        st_stall = st && (n == DEPTH) && !pop;
        ld_stall = 1'b0;
        if (ld && !st) begin
            for (int i = 0; i < n; i++)
                if (pend[i].addr[AW-1:2] == la[AW-1:2]) y = i;
        end
        if (y >= 0) begin
            if (FWD && pend[y].be == 4'hF) begin
                e.fwd   = 1'b1;
                e.ldata = pend[y].data;
            end else begin
                ld_stall = 1'b1;
            end
        end
        e.stall = st_stall || ld_stall;
        push    = st && !e.stall;
        e.full  = (n == DEPTH);
        e.empty = (n == 0);
        e.mreq  = (n > 0);
        if (n > 0) begin
            e.maddr = {pend[0].addr[AW-1:2], 2'b00};
            e.mdata = pend[0].data;
            e.mbe   = pend[0].be;
        end
        return e;
    endfunction

    task automatic cycle(input logic st, input logic [AW-1:0] sa, input logic [31:0] sd,
                         input logic [3:0] sbe, input logic ld, input logic [AW-1:0] la,
                         input logic ack);
        exp_t e;
        logic push;
        logic pop;
        @(posedge Clk);
        #1;
        St_Req = st; St_Addr = sa; St_Data = sd; St_BE = sbe;
        Ld_Req = ld; Ld_Addr = la; Mem_Ack = ack;
        e = predict(st, ld, la, ack, push, pop);
        cycq.push_back(e);
        if (pop) void'(pend.pop_front());
        if (push) begin
            pend.push_back('{addr: sa, data: sd, be: sbe});
            beatq.push_back('{addr: {sa[AW-1:2], 2'b00}, data: sd, be: sbe});
        end
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, '0, '0, '0, 1'b0, '0, ack);
    endtask

    task automatic store(input logic [AW-1:0] sa, input logic [31:0] sd, input logic [3:0] sbe, input logic ack);
        cycle(1'b1, sa, sd, sbe, 1'b0, '0, ack);
    endtask

    task automatic load(input logic [AW-1:0] la, input logic ack);
        cycle(1'b0, '0, '0, '0, 1'b1, la, ack);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, Mem_Req, 1'b0);
        chk({tag, "_empty"}, Empty, 1'b1);
        chk({tag, "_full"}, Full, 1'b0);
        chk({tag, "_stall"}, Stall, 1'b0);
        chk({tag, "_mem_addr"}, Mem_Addr, '0);
        chk({tag, "_mem_data"}, Mem_Data, '0);
        chk({tag, "_mem_be"}, Mem_BE, '0);
        chk({tag, "_ld_fwd"}, Ld_Fwd, 1'b0);
        chk({tag, "_ld_data"}, Ld_Data, '0);
    endtask

    task automatic do_reset();
        exp_t e;
        logic push;
        logic pop;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        St_Req = 1'b0; Ld_Req = 1'b0; Mem_Ack = 1'b0;
        pend.delete();
        beatq.delete();
        #1;
        check_reset_outputs("mid_reset");
        e = predict(1'b0, 1'b0, '0, 1'b0, push, pop);
        cycq.push_back(e);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    // Monitor: compares per-cycle predictions and every completed memory beat.
    initial begin
        exp_t e;
        st_t  b;
        forever begin
            @(negedge Clk);
            if (cycq.size() > 0) begin
                e = cycq.pop_front();
                chk("stall", Stall, e.stall);
                chk("ld_fwd", Ld_Fwd, e.fwd);
                chk("ld_data", Ld_Data, e.ldata);
                chk("full", Full, e.full);
                chk("empty", Empty, e.empty);
                chk("mem_req", Mem_Req, e.mreq);
                if (e.mreq) begin
                    chk("head_addr", Mem_Addr, e.maddr);
                    chk("head_data", Mem_Data, e.mdata);
                    chk("head_be", Mem_BE, e.mbe);
                end
            end
            if (Rst && Mem_Req && Mem_Ack) begin
                if (beatq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got addr %h, expected no beat", Mem_Addr);
                end else begin
                    b = beatq.pop_front();
                    chk("beat_addr", Mem_Addr, b.addr);
                    chk("beat_data", Mem_Data, b.data);
                    chk("beat_be", Mem_BE, b.be);
                end
            end
        end
    end

    initial begin
        logic          st;
        logic          ld;
        logic [3:0]    be;
        logic [AW-1:0] a;
        #2;
        check_reset_outputs("por");
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Reset in the middle of a handshake discards the pending store.
        store(12'h010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        idle(1'b0);
        idle(1'b0);
        do_reset();
        repeat (3) idle(1'b1);

        // Fill, stall on the 5th, then accept it as the head retires.
        store(12'h000, 32'h1000_0000, 4'hF, 1'b0);
        store(12'h004, 32'h1000_0004, 4'hF, 1'b0);
        store(12'h008, 32'h1000_0008, 4'hF, 1'b0);
        store(12'h00C, 32'h1000_000C, 4'hF, 1'b0);
        store(12'h010, 32'h1000_0010, 4'hF, 1'b0);
        store(12'h010, 32'h1000_0010, 4'hF, 1'b1);
        idle(1'b0);
        repeat (6) idle(1'b1);

        // Ordering with Mem_Ack held high.
        store(12'h100, 32'hAAAA_AAAA, 4'hF, 1'b1);
        store(12'h104, 32'h5555_5555, 4'h3, 1'b1);
        repeat (4) idle(1'b1);

        // Full-word match: forwarded or stalled depending on build.
        store(12'h020, 32'h1234_5678, 4'hF, 1'b0);
        repeat (3) load(12'h022, 1'b0);
        load(12'h022, 1'b1);
        load(12'h022, 1'b0);

        // Partial-BE match always stalls until the entry drains.
        store(12'h040, 32'h0000_00EE, 4'h1, 1'b0);
        repeat (3) load(12'h040, 1'b0);
        load(12'h040, 1'b1);
        load(12'h040, 1'b0);

        // Youngest match decides: partial then full to the same word.
        store(12'h060, 32'h0000_0011, 4'h1, 1'b0);
        store(12'h060, 32'hCAFE_F00D, 4'hF, 1'b0);
        load(12'h063, 1'b0);
        repeat (3) idle(1'b1);

        // Back-pressure hold, then a stray ack while empty.
        store(12'h0F8, 32'h0BAD_CAFE, 4'h6, 1'b0);
        repeat (10) idle(1'b0);
        repeat (2) idle(1'b1);
        repeat (3) idle(1'b1);

        // Randomised traffic over a small address window to provoke matches.
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 2) == 0);
            ld = ($urandom_range(0, 2) == 0);
            be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
            a  = 12'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            cycle(st, a, $urandom, be, ld, 12'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 2 * DEPTH + 2; i++) idle(1'b1);
        @(negedge Clk);
        @(negedge Clk);
        chk("final_empty", Empty, 1'b1);
        chk("beats_outstanding", beatq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
